// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan FSM states and active-low hex segment table
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low {g,f,e,d,c,b,a} decoder
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/module_seg7_scan.sv
// module_seg7_scan: multiplexed common-anode display scanner with anti-ghost gap and frame-coherent data
module module_seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_toggle,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    data_valid,
  input  logic                    blank_lz,
  output logic [N_DIGITS-1:0]     an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  scan_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tog_q;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [N_DIGITS-1:0] sdp_q, sdp_d, ddp_q, ddp_d, an_q, an_d;
  logic pend_q, pend_d;
  logic [6:0] seg_q, seg_d, dec;
  logic dp_q, dp_d;
  logic scan_edge, commit, wrap, lz;
  logic [3:0] nib;

  hex_to_seg7 u_dec (.nib_i(nib), .seg_o(dec));

  // scan sequencing: edges start or advance a digit, edges during the gap are dropped
  always_comb begin
    scan_edge = scan_toggle ^ tog_q;
    wrap = idx_q == IW'(N_DIGITS - 1);
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    commit = 1'b0;
    if (state_q == IDLE && scan_edge) begin
      state_d = BLANK;
      cnt_d = '0;
      commit = 1'b1;
    end else if (state_q == BLANK) begin
      state_d = cnt_q == CW'(BLANK_CYCLES - 1) ? DRIVE : BLANK;
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == DRIVE && scan_edge) begin
      state_d = BLANK;
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + 1'b1;
      commit = wrap;
    end
  end

  // shadow capture and frame-boundary commit; a load coinciding with commit bypasses the shadow
  always_comb begin
    shadow_d = data_valid ? data_in : shadow_q;
    sdp_d = data_valid ? dp_in : sdp_q;
    pend_d = commit ? 1'b0 : (data_valid | pend_q);
    disp_d = commit ? (data_valid ? data_in : shadow_q) : disp_q;
    ddp_d = commit ? (data_valid ? dp_in : sdp_q) : ddp_q;
  end

  // output drive for the next cycle, with leading-zero suppression above digit 0
  always_comb begin
    lz = 1'b1;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'h0) lz = 1'b0;
    nib = disp_q[4*idx_q +: 4];
    an_d = state_d == DRIVE ? ~(N_DIGITS'(1) << idx_q) : '1;
    seg_d = (state_d == DRIVE && !(blank_lz && idx_q != '0 && lz)) ? dec : SEG_OFF;
    dp_d = state_d == DRIVE ? ~ddp_q[idx_q] : 1'b1;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tog_q    <= 1'b0;
      shadow_q <= '0;
      sdp_q    <= '0;
      disp_q   <= '0;
      ddp_q    <= '0;
      pend_q   <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tog_q    <= scan_toggle;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      disp_q   <= disp_d;
      ddp_q    <= ddp_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an_o = an_q;
  assign seg_o = seg_q;
  assign dp_o = dp_q;
endmodule
